// File: rtl/seg7_pkg.sv
// Shared 7-segment patterns {a,b,c,d,e,f,g} (a = bit 6, 1 = lit) and the BCD digit decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of a ripple up/down BCD counter with carry/borrow chaining.
module bcd_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       carry_i,
    input  logic       borrow_i,
    output logic [3:0] digit_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] digit_q, digit_d;
    logic       step_up, step_dn;

    always_comb begin
        step_up  = inc_i & carry_i;
        step_dn  = dec_i & borrow_i;
        carry_o  = step_up & (digit_q == 4'd9);
        borrow_o = step_dn & (digit_q == 4'd0);
        digit_d  = digit_q;
        if (clear_i) begin
            digit_d = 4'd0;
        end else if (step_up) begin
            digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else if (step_dn) begin
            // Out-of-range values fold back to 9 so the digit can never leave 0-9.
            digit_d = (digit_q == 4'd0 || digit_q > 4'd9) ? 4'd9 : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;

endmodule

// File: rtl/bcd_counter_7seg_mux.sv
// Multi-digit BCD up/down counter with prescaler, wrap pulse and multiplexed 7-segment scan.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module bcd_counter_7seg_mux
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned COUNT_DIV  = 1,
    parameter int unsigned SCAN_DIV   = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en_i,
    input  logic                    up_dn_i,
    input  logic                    clear_i,
    output logic [4*NUM_DIGITS-1:0] bcd_o,
    output logic                    wrap_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(COUNT_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           presc_q, presc_d;
    logic [SW-1:0]           scan_q, scan_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    wrap_q, wrap_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick, scan_wrap;
    logic [NUM_DIGITS:0]     carry, borrow;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [3:0]              sel_digit;

    assign tick      = en_i & (presc_q == PRESC_MAX);
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
        bcd_digit u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear_i  (clear_i),
            .inc_i    (tick & up_dn_i),
            .dec_i    (tick & ~up_dn_i),
            .carry_i  (carry[g]),
            .borrow_i (borrow[g]),
            .digit_o  (bcd[4*g +: 4]),
            .carry_o  (carry[g+1]),
            .borrow_o (borrow[g+1])
        );
    end

    always_comb begin
        presc_d = presc_q;
        if (clear_i) begin
            presc_d = '0;
        end else if (en_i) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
        // Ripple out of the top digit means every digit rolled over.
        wrap_d    = ~clear_i & (carry[NUM_DIGITS] | borrow[NUM_DIGITS]);
        scan_wrap = (scan_q == SCAN_MAX);
        scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
        idx_d     = idx_q;
        if (scan_wrap) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic lead_zero, sel_blank;
`endif

    always_comb begin
        an_d      = '0;
        sel_digit = 4'd0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        lead_zero = 1'b1;
        sel_blank = 1'b0;
`endif
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            lead_zero = lead_zero & (bcd[4*i +: 4] == 4'd0);
`endif
            if (idx_q == IW'(i)) begin
                an_d[i]   = 1'b1;
                sel_digit = bcd[4*i +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
                sel_blank = lead_zero && (i != 0);
`endif
            end
        end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        seg_d = sel_blank ? SEG_BLANK : digit_to_seg(sel_digit);
`else
        seg_d = digit_to_seg(sel_digit);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
        end else begin
            presc_q <= presc_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bcd_o  = bcd;
    assign wrap_o = wrap_q;
    assign seg_o  = seg_q;
    assign an_o   = an_q;

endmodule
